// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin arbiter in front of the
// 32:1 mux tree.
package mux_arb_pkg;

   localparam int unsigned N_REQ = 32;
   localparam int unsigned SEL_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [N_REQ-1:0] req_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping from the top index back to zero.
module rr_priority_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  sel_t             ptr,
   output logic             any,
   output sel_t             idx
);

   localparam logic [SEL_W:0] NReqW = (SEL_W+1)'(N_REQ);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   sel_t               off;
   logic [SEL_W:0]     sum;

   always_comb begin
      // Rotating right by ptr puts the highest-priority requester at bit 0.
      dbl = {req, req} >> ptr;
      rot = dbl[N_REQ-1:0];
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = sel_t'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NReqW) begin
         sum = sum - NReqW;
      end
      idx = sum[SEL_W-1:0];
      any = |req;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin grant controller driving the mux selector; bounded hold time
// and one dead cycle between grants so sel never moves under a live grant.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
   localparam sel_t       LastIdx  = sel_t'(N_REQ - 1);

   arb_state_t state_q, state_d;
   sel_t       ptr_q, ptr_d;
   sel_t       sel_q, sel_d;
   logic [7:0] hcnt_q, hcnt_d;
   logic       timeout_q, timeout_d;

   logic pick_any;
   sel_t pick_idx;
   logic grant_entry;
   logic hold_end;
   logic withdrawn;

   rr_priority_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      hcnt_d      = hcnt_q;
      timeout_d   = 1'b0;
      grant_entry = 1'b0;
      hold_end    = (hcnt_q == HoldLast);
      withdrawn   = ~req[sel_q];

      unique case (state_q)
         IDLE: begin
            grant_entry = pick_any;
         end
         GRANT: begin
            if (done || withdrawn || hold_end) begin
               state_d   = RELEASE;
               // Forced release only when nothing else already ended the grant.
               timeout_d = hold_end && !done && !withdrawn;
            end else begin
               hcnt_d = hcnt_q + 8'd1;
            end
         end
         RELEASE: begin
            if (pick_any) begin
               grant_entry = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (grant_entry) begin
         state_d = GRANT;
         sel_d   = pick_idx;
         ptr_d   = (pick_idx == LastIdx) ? '0 : pick_idx + sel_t'(1);
         hcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sel_q     <= '0;
         hcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         hcnt_q    <= hcnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == GRANT) begin
         gnt[sel_q] = 1'b1;
      end
   end

   assign sel       = sel_q;
   assign gnt_valid = (state_q == GRANT);
   assign timeout   = timeout_q;
   assign busy      = (state_q != IDLE);

   a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
   a_timeout_rel : assert property (@(posedge clk) disable iff (reset)
      timeout |-> state_q == RELEASE);
   a_hcnt_bound : assert property (@(posedge clk) disable iff (reset)
      32'(hcnt_q) < MAX_HOLD);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle;
// directed checks confirm grant order, hold length and timeout counts.
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 16;

   logic        clk;
   logic        reset;
   logic [31:0] req;
   logic        done;
   logic [4:0]  sel;
   logic [31:0] gnt;
   logic        gnt_valid;
   logic        timeout;
   logic        busy;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .sel       (sel),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .timeout   (timeout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  sel;
      logic [31:0] gnt;
      logic        gv;
      logic        tout;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: 0 idle, 1 grant, 2 release.
   int m_state = 0;
   int m_ptr   = 0;
   int m_sel   = 0;
   int m_hcnt  = 0;

   logic prev_gv  = 1'b0;
   int   cur_run  = 0;
   int   last_run = 0;
   int   tout_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_grant(input logic [31:0] r);
      int w;
      w = -1;
      for (int k = 0; k < 32; k++) begin
         if (w < 0 && r[(m_ptr + k) % 32]) w = (m_ptr + k) % 32;
      end
      m_sel   = w;
      m_ptr   = (w + 1) % 32;
      m_hcnt  = 0;
      m_state = 1;
   endtask

   task automatic model_step(input logic rst, input logic [31:0] r, input logic d);
      exp_t e;
      logic tout;
      tout = 1'b0;
      if (rst) begin
         m_state = 0;
         m_ptr   = 0;
         m_sel   = 0;
         m_hcnt  = 0;
      end else begin
         case (m_state)
            0: if (r != 0) model_grant(r);
            1: begin
               if (d || !r[m_sel] || m_hcnt == MAX_HOLD - 1) begin
                  tout    = !d && r[m_sel] && (m_hcnt == MAX_HOLD - 1);
                  m_state = 2;
               end else begin
                  m_hcnt++;
               end
            end
            default: begin
               if (r != 0) model_grant(r);
               else m_state = 0;
            end
         endcase
      end
      e.sel  = 5'(m_sel);
      e.gnt  = (m_state == 1) ? (32'd1 << m_sel) : 32'd0;
      e.gv   = (m_state == 1);
      e.tout = tout;
      e.busy = (m_state != 0);
      exp_q.push_back(e);
   endtask

   task automatic step(input logic rst, input logic [31:0] r, input logic d);
      exp_t e;
      reset = rst;
      req   = r;
      done  = d;
      model_step(rst, r, d);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq("sel", {27'd0, sel}, {27'd0, e.sel});
         check_eq("gnt", gnt, e.gnt);
         check_eq("gnt_valid", {31'd0, gnt_valid}, {31'd0, e.gv});
         check_eq("timeout", {31'd0, timeout}, {31'd0, e.tout});
         check_eq("busy", {31'd0, busy}, {31'd0, e.busy});
      end
      if (gnt_valid === 1'b1 && !prev_gv) grant_log.push_back(int'(sel));
      if (gnt_valid === 1'b1) begin
         cur_run++;
      end else begin
         if (prev_gv) last_run = cur_run;
         cur_run = 0;
      end
      if (timeout === 1'b1) tout_cnt++;
      prev_gv = (gnt_valid === 1'b1);
   endtask

   task automatic check_log(input string tag, input int want[$]);
      check_eq({tag, "_len"}, 32'(grant_log.size()), 32'(want.size()));
      for (int i = 0; i < want.size() && i < grant_log.size(); i++) begin
         check_eq(tag, 32'(grant_log[i]), 32'(want[i]));
      end
   endtask

   initial begin
      int want[$];
      logic [31:0] r;

      reset = 1'b1;
      req   = '0;
      done  = 1'b0;

      step(1, 0, 0);
      step(1, 0, 0);

      // Single request.
      grant_log.delete();
      step(0, 32'h0000_0010, 0);
      step(0, 32'h0000_0010, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      want = '{4};
      check_log("single_order", want);

      // Round robin between inputs 0 and 2.
      grant_log.delete();
      for (int i = 0; i < 8; i++) step(0, 32'h0000_0005, 1);
      step(0, 0, 0);
      want = '{0, 2, 0, 2};
      check_log("rr_order", want);

      // Wrap-around from 30 through 31 to 0.
      grant_log.delete();
      step(0, 32'h4000_0000, 0);
      step(0, 32'h4000_0000, 1);
      for (int i = 0; i < 4; i++) step(0, 32'h8000_0001, 1);
      step(0, 0, 0);
      want = '{30, 31, 0};
      check_log("wrap_order", want);

      // Timeout with req[7] held and no done.
      grant_log.delete();
      tout_cnt = 0;
      for (int i = 0; i < 40; i++) step(0, 32'h0000_0080, 0);
      check_eq("timeout_hold_len", 32'(last_run), 32'(MAX_HOLD));
      check_eq("timeout_pulses", 32'(tout_cnt), 32'd2);
      step(0, 0, 0);
      step(0, 0, 0);
      check_eq("timeout_after_drop", 32'(tout_cnt), 32'd2);
      want = '{7, 7, 7};
      check_log("timeout_order", want);

      // Withdrawal mid-grant.
      tout_cnt = 0;
      for (int i = 0; i < 4; i++) step(0, 32'h0000_0200, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check_eq("withdraw_tout", 32'(tout_cnt), 32'd0);
      check_eq("withdraw_len", 32'(last_run), 32'd4);

      // done coincides with the final hold cycle.
      tout_cnt = 0;
      for (int i = 0; i < 16; i++) step(0, 32'h0000_0008, 0);
      step(0, 32'h0000_0008, 1);
      step(0, 0, 0);
      check_eq("simul_tout", 32'(tout_cnt), 32'd0);
      check_eq("simul_len", 32'(last_run), 32'(MAX_HOLD));

      // Reset during a live grant.
      step(0, 32'h0000_1000, 0);
      step(0, 32'h0000_1000, 0);
      step(1, 32'h0000_1000, 0);
      check_eq("rst_mid_gv", {31'd0, gnt_valid}, 32'd0);
      check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
      step(0, 0, 0);

      // Fairness: all 32 requesting after reset.
      grant_log.delete();
      for (int i = 0; i < 64; i++) step(0, 32'hFFFF_FFFF, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      want.delete();
      for (int i = 0; i < 32; i++) want.push_back(i);
      check_log("fair_order", want);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         r = $urandom & $urandom & $urandom;
         step(($urandom_range(0, 99) == 0), r, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
